decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Parametrised, registered decode stage between fetch and execute in the pipelined RV core.
- Accepts one fetched instruction per cycle over a valid/ready handshake and decodes it.
- Produces control bundle, register indices, sign-extended immediate and an illegal flag, one cycle later.
- Has a one-entry skid buffer for full throughput under back-pressure, a flush input, and build-time XLEN, M-extension and W-op selection.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- ENABLE_M, 0, 1 decodes RV M-extension (MUL/DIV/REM families); 0 flags them illegal.
- ENABLE_W, 1, 1 decodes OP-IMM-32/OP-32 word ops; forced inert when XLEN=32.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept
- in_pc  in  XLEN  instruction PC
- in_instr  in  32  raw instruction
- flush  in  1  kill all held instructions
- out_valid  out  1  decoded instruction available
- out_ready  in  1  execute accepts
- out_pc  out  XLEN  PC of decoded instruction
- out_ctl  out  $bits(control_t)  control bundle (op, alufunc, regWrite, selectA/B, pcSrc, pcTarget, wbSelect, memRw, branch, extAluOut)
- out_rs1, out_rs2, out_rd  out  5 each  register indices
- out_imm  out  XLEN  sign-extended immediate
- out_illegal  out  1  unsupported or malformed encoding

Behaviour:
- Reset (resetn low, async): out_valid=0, skid_valid=0, in_ready=1. All out_* data outputs = 0.
- Accept condition: in_valid & in_ready. Output transfer: out_valid & out_ready.
- in_ready = !skid_valid. It is registered state, not combinational from out_ready.
- Latency: an instruction accepted at edge N has out_valid=1 after edge N, with decoded fields stable.
- Output register (OR) holds decoded fields. Skid register (SK) holds raw pc+instr.
- Each edge:
  - OR empty or transferring: OR loads decode(SK) if SK valid, else decode(accepted input), else clears valid.
  - OR loaded from SK: a same-cycle accepted input goes into SK.
  - OR full and not transferring: an accepted input goes into SK.
- Ordering is strictly FIFO. Sustained throughput is 1/cycle with out_ready=1.
- out_* fields hold stable while out_valid & !out_ready.
- flush high at an edge: OR and SK valid cleared. Input presented that cycle is dropped. in_ready=1 next cycle. flush overrides every load.
- Decode rules:
  - Immediates follow RISC-V I/S/B/U/J formats, sign-extended to XLEN. U-type places imm[31:12] then sign-extends.
  - Shift-immediates: shamt width is 6 for XLEN=64 and 5 otherwise. instr[25]=1 when XLEN=32 is illegal. W-shifts with instr[25]=1 are illegal.
  - funct7 not in {0000000, 0100000(SUB/SRA only), 0000001(M, ENABLE_M=1)} is illegal.
  - Unknown opcode or funct3 is illegal.
  - Illegal instruction: out_ctl=0 (no regWrite, memRw=0, pcSrc=0), out_illegal=1. It still flows as a normal valid transfer.
  - W ops (ENABLE_W=0 or XLEN=32) are illegal. Legal W ops set extAluOut.
  - LD/SD at XLEN=32 are illegal. LW/SW are supported at both widths.
  - rs1/rs2/rd are always the raw fields [19:15]/[24:20]/[11:7]. Downstream qualifies them by op.
- Mid-operation reset: all held instructions discarded, no partial output.

Decomposition:
- pipes package holds opcode constants (F7_*), funct3/funct6/funct7 constants, the alufunc_t enum (extended with MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU and W variants), branch_t, and control_t.
- One combinational sub-module, decode_logic (raw_instr -> control_t, imm, illegal; parameters XLEN, ENABLE_M, ENABLE_W), is instantiated twice: on the SK path and the input path.
- decode_stage owns only the handshake, skid buffer and output register.

Test Plan:
- Reset then addi x1,x0,5 (0x00500093) with out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, imm=5, regWrite=1, selectB=1, alufunc=ADD, illegal=0.
- beq x1,x2,-4 (0xFE208EE3), XLEN=64 -> imm=0xFFFF_FFFF_FFFF_FFFC, branch=BRANCH_BEQ, alufunc=SUB, regWrite=0.
- out_ready=0, push A then B back-to-back -> after B in_ready=0 and out_* shows A steady. Raise out_ready -> A, then B, next cycle in_ready=1.
- OR and SK full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and none of the three instructions ever appears.
- 0xFFFFFFFF -> out_illegal=1, out_ctl=0. mul x0,x1,x2 (0x02208033): ENABLE_M=0 gives illegal=1; ENABLE_M=1 gives alufunc=MUL.
- XLEN=32: slli x1,x1,32 (0x02009093) -> illegal=1. addiw (0x0010809B) -> illegal=1.

Source files
------------

// File: rtl/pipes.sv
// Shared decode types: opcode/funct constants, ALU and branch encodings, control bundle.
package pipes;

  localparam logic [6:0] F7_LOAD    = 7'b0000011;
  localparam logic [6:0] F7_OPIMM   = 7'b0010011;
  localparam logic [6:0] F7_AUIPC   = 7'b0010111;
  localparam logic [6:0] F7_OPIMM32 = 7'b0011011;
  localparam logic [6:0] F7_STORE   = 7'b0100011;
  localparam logic [6:0] F7_OP      = 7'b0110011;
  localparam logic [6:0] F7_LUI     = 7'b0110111;
  localparam logic [6:0] F7_OP32    = 7'b0111011;
  localparam logic [6:0] F7_BRANCH  = 7'b1100011;
  localparam logic [6:0] F7_JALR    = 7'b1100111;
  localparam logic [6:0] F7_JAL     = 7'b1101111;

  localparam logic [2:0] FUNCT3_ADD = 3'b000;
  localparam logic [2:0] FUNCT3_SLL = 3'b001;
  localparam logic [2:0] FUNCT3_SR  = 3'b101;

  localparam logic [5:0] FUNCT6_BASE = 6'b000000;
  localparam logic [5:0] FUNCT6_ALT  = 6'b010000;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // First 16 entries are ordered by {muldiv, funct3} so they can be indexed directly.
  typedef enum logic [4:0] {
    ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
    ALU_SUB, ALU_SRA,
    ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW,
    ALU_MULW, ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW
  } alufunc_t;

  typedef enum logic [2:0] {
    BRANCH_NONE, BRANCH_BEQ, BRANCH_BNE, BRANCH_BLT,
    BRANCH_BGE, BRANCH_BLTU, BRANCH_BGEU, BRANCH_JUMP
  } branch_t;

  typedef enum logic [1:0] {SEL_A_RS1, SEL_A_PC, SEL_A_ZERO} sel_a_t;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_t;
  typedef enum logic [1:0] {MEM_NONE, MEM_READ, MEM_WRITE} mem_rw_t;

  typedef struct packed {
    logic [6:0] op;
    alufunc_t   alufunc;
    logic       regWrite;
    sel_a_t     selectA;
    logic       selectB;
    logic       pcSrc;
    logic       pcTarget;
    wb_sel_t    wbSelect;
    mem_rw_t    memRw;
    branch_t    branch;
    logic       extAluOut;
  } control_t;

  function automatic alufunc_t alu_f3(input logic [2:0] f3, input logic muldiv);
    return alufunc_t'({1'b0, muldiv, f3});
  endfunction

endpackage

// File: rtl/decode_logic.sv
// Combinational RV instruction decoder: raw instruction to control bundle, immediate, illegal flag.
module decode_logic
  import pipes::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter bit          ENABLE_M = 1'b0,
  parameter bit          ENABLE_W = 1'b1
) (
  input  logic [31:0]     instr,
  output control_t        ctl,
  output logic [XLEN-1:0] imm,
  output logic            illegal,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd
);

  localparam bit RV64 = (XLEN == 64);
  localparam bit W_OK = ENABLE_W && RV64;

  logic [6:0] opcode, funct7;
  logic [5:0] funct6;
  logic [2:0] funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  control_t c;
  logic bad;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign funct6 = instr[31:26];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

  always_comb begin
    c      = '0;
    c.op   = opcode;
    bad    = 1'b0;
    imm    = '0;
    case (opcode)
      F7_LUI: begin
        c.regWrite = 1'b1; c.selectA = SEL_A_ZERO; c.selectB = 1'b1; imm = imm_u;
      end
      F7_AUIPC: begin
        c.regWrite = 1'b1; c.selectA = SEL_A_PC; c.selectB = 1'b1; imm = imm_u;
      end
      F7_JAL: begin
        c.regWrite = 1'b1; c.wbSelect = WB_PC4; c.pcSrc = 1'b1; c.branch = BRANCH_JUMP;
        imm = imm_j;
      end
      F7_JALR: begin
        c.regWrite = 1'b1; c.wbSelect = WB_PC4; c.pcSrc = 1'b1; c.pcTarget = 1'b1;
        c.branch = BRANCH_JUMP; imm = imm_i; bad = (funct3 != 3'b000);
      end
      F7_BRANCH: begin
        c.pcSrc = 1'b1; imm = imm_b;
        case (funct3)
          3'b000:  begin c.branch = BRANCH_BEQ;  c.alufunc = ALU_SUB;  end
          3'b001:  begin c.branch = BRANCH_BNE;  c.alufunc = ALU_SUB;  end
          3'b100:  begin c.branch = BRANCH_BLT;  c.alufunc = ALU_SLT;  end
          3'b101:  begin c.branch = BRANCH_BGE;  c.alufunc = ALU_SLT;  end
          3'b110:  begin c.branch = BRANCH_BLTU; c.alufunc = ALU_SLTU; end
          3'b111:  begin c.branch = BRANCH_BGEU; c.alufunc = ALU_SLTU; end
          default: bad = 1'b1;
        endcase
      end
      F7_LOAD: begin
        c.regWrite = 1'b1; c.selectB = 1'b1; c.wbSelect = WB_MEM; c.memRw = MEM_READ;
        imm = imm_i;
        case (funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: bad = 1'b0;
          3'b011, 3'b110:                         bad = !RV64;
          default:                                bad = 1'b1;
        endcase
      end
      F7_STORE: begin
        c.selectB = 1'b1; c.memRw = MEM_WRITE; imm = imm_s;
        case (funct3)
          3'b000, 3'b001, 3'b010: bad = 1'b0;
          3'b011:                 bad = !RV64;
          default:                bad = 1'b1;
        endcase
      end
      F7_OPIMM: begin
        c.regWrite = 1'b1; c.selectB = 1'b1; imm = imm_i;
        c.alufunc = alu_f3(funct3, 1'b0);
        // On RV32 instr[25] would be shamt[5], which does not exist there.
        if (funct3 == FUNCT3_SLL)
          bad = (funct6 != FUNCT6_BASE) || (!RV64 && instr[25]);
        else if (funct3 == FUNCT3_SR) begin
          if (funct6 == FUNCT6_ALT) c.alufunc = ALU_SRA;
          bad = ((funct6 != FUNCT6_BASE) && (funct6 != FUNCT6_ALT)) || (!RV64 && instr[25]);
        end
      end
      F7_OP: begin
        c.regWrite = 1'b1;
        case (funct7)
          FUNCT7_BASE:   c.alufunc = alu_f3(funct3, 1'b0);
          FUNCT7_MULDIV: begin c.alufunc = alu_f3(funct3, 1'b1); bad = !ENABLE_M; end
          FUNCT7_ALT: begin
            if (funct3 == FUNCT3_ADD)     c.alufunc = ALU_SUB;
            else if (funct3 == FUNCT3_SR) c.alufunc = ALU_SRA;
            else                          bad = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end
      F7_OPIMM32: begin
        c.regWrite = 1'b1; c.selectB = 1'b1; c.extAluOut = 1'b1; imm = imm_i;
        case (funct3)
          3'b000: c.alufunc = ALU_ADDW;
          3'b001: begin c.alufunc = ALU_SLLW; bad = (funct7 != FUNCT7_BASE); end
          3'b101: begin
            c.alufunc = (funct7 == FUNCT7_ALT) ? ALU_SRAW : ALU_SRLW;
            bad = (funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT);
          end
          default: bad = 1'b1;
        endcase
        if (!W_OK) bad = 1'b1;
      end
      F7_OP32: begin
        c.regWrite = 1'b1; c.extAluOut = 1'b1;
        case ({funct7, funct3})
          {FUNCT7_BASE, 3'b000}:   c.alufunc = ALU_ADDW;
          {FUNCT7_ALT, 3'b000}:    c.alufunc = ALU_SUBW;
          {FUNCT7_BASE, 3'b001}:   c.alufunc = ALU_SLLW;
          {FUNCT7_BASE, 3'b101}:   c.alufunc = ALU_SRLW;
          {FUNCT7_ALT, 3'b101}:    c.alufunc = ALU_SRAW;
          {FUNCT7_MULDIV, 3'b000}: c.alufunc = ALU_MULW;
          {FUNCT7_MULDIV, 3'b100}: c.alufunc = ALU_DIVW;
          {FUNCT7_MULDIV, 3'b101}: c.alufunc = ALU_DIVUW;
          {FUNCT7_MULDIV, 3'b110}: c.alufunc = ALU_REMW;
          {FUNCT7_MULDIV, 3'b111}: c.alufunc = ALU_REMUW;
          default:                 bad = 1'b1;
        endcase
        if (!W_OK || ((funct7 == FUNCT7_MULDIV) && !ENABLE_M)) bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
  end

  assign ctl     = bad ? control_t'('0) : c;
  assign illegal = bad;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready handshake, one-entry raw skid buffer, decoded output register.
module decode_stage
  import pipes::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter bit          ENABLE_M = 1'b0,
  parameter bit          ENABLE_W = 1'b1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output control_t        out_ctl,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  logic            or_valid, sk_valid;
  logic [XLEN-1:0] sk_pc;
  logic [31:0]     sk_instr;
  logic            accept, or_free;

  control_t        sk_ctl, in_ctl;
  logic [XLEN-1:0] sk_imm, in_imm;
  logic            sk_ill, in_ill;
  logic [4:0]      sk_rs1, sk_rs2, sk_rd, in_rs1, in_rs2, in_rd;

  decode_logic #(.XLEN(XLEN), .ENABLE_M(ENABLE_M), .ENABLE_W(ENABLE_W)) u_dec_sk (
    .instr(sk_instr), .ctl(sk_ctl), .imm(sk_imm), .illegal(sk_ill),
    .rs1(sk_rs1), .rs2(sk_rs2), .rd(sk_rd)
  );

  decode_logic #(.XLEN(XLEN), .ENABLE_M(ENABLE_M), .ENABLE_W(ENABLE_W)) u_dec_in (
    .instr(in_instr), .ctl(in_ctl), .imm(in_imm), .illegal(in_ill),
    .rs1(in_rs1), .rs2(in_rs2), .rd(in_rd)
  );

  assign in_ready  = !sk_valid;
  assign out_valid = or_valid;
  assign accept    = in_valid && !sk_valid;
  assign or_free   = !or_valid || out_ready;

  // in_ready is low whenever the skid is full, so draining the skid never coincides with an accept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      or_valid    <= 1'b0;
      sk_valid    <= 1'b0;
      sk_pc       <= '0;
      sk_instr    <= '0;
      out_pc      <= '0;
      out_ctl     <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd      <= '0;
      out_imm     <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      or_valid <= 1'b0;
      sk_valid <= 1'b0;
    end else if (or_free) begin
      if (sk_valid) begin
        or_valid    <= 1'b1;
        sk_valid    <= 1'b0;
        out_pc      <= sk_pc;
        out_ctl     <= sk_ctl;
        out_rs1     <= sk_rs1;
        out_rs2     <= sk_rs2;
        out_rd      <= sk_rd;
        out_imm     <= sk_imm;
        out_illegal <= sk_ill;
      end else if (accept) begin
        or_valid    <= 1'b1;
        out_pc      <= in_pc;
        out_ctl     <= in_ctl;
        out_rs1     <= in_rs1;
        out_rs2     <= in_rs2;
        out_rd      <= in_rd;
        out_imm     <= in_imm;
        out_illegal <= in_ill;
      end else begin
        or_valid <= 1'b0;
      end
    end else if (accept) begin
      sk_valid <= 1'b1;
      sk_pc    <= in_pc;
      sk_instr <= in_instr;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage across three builds: RV64, RV64 with M, and RV32.
module tb_decode_stage;
  import pipes::*;

  logic        clk = 1'b0;
  logic        resetn, in_valid, flush, out_ready;
  logic [63:0] in_pc;
  logic [31:0] in_instr;

  logic        a_in_ready, a_out_valid, a_ill;
  logic [63:0] a_pc, a_imm;
  control_t    a_ctl;
  logic [4:0]  a_rs1, a_rs2, a_rd;

  logic        m_in_ready, m_out_valid, m_ill;
  logic [63:0] m_pc, m_imm;
  control_t    m_ctl;
  logic [4:0]  m_rs1, m_rs2, m_rd;

  logic        h_in_ready, h_out_valid, h_ill;
  logic [31:0] h_pc, h_imm;
  control_t    h_ctl;
  logic [4:0]  h_rs1, h_rs2, h_rd;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(64), .ENABLE_M(1'b0), .ENABLE_W(1'b1)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .flush(flush), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_pc(a_pc), .out_ctl(a_ctl), .out_rs1(a_rs1),
    .out_rs2(a_rs2), .out_rd(a_rd), .out_imm(a_imm), .out_illegal(a_ill)
  );

  decode_stage #(.XLEN(64), .ENABLE_M(1'b1), .ENABLE_W(1'b1)) dut_m (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .flush(flush), .out_valid(m_out_valid),
    .out_ready(out_ready), .out_pc(m_pc), .out_ctl(m_ctl), .out_rs1(m_rs1),
    .out_rs2(m_rs2), .out_rd(m_rd), .out_imm(m_imm), .out_illegal(m_ill)
  );

  decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .ENABLE_W(1'b1)) dut_32 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(h_in_ready),
    .in_pc(in_pc[31:0]), .in_instr(in_instr), .flush(flush), .out_valid(h_out_valid),
    .out_ready(out_ready), .out_pc(h_pc), .out_ctl(h_ctl), .out_rs1(h_rs1),
    .out_rs2(h_rs2), .out_rd(h_rd), .out_imm(h_imm), .out_illegal(h_ill)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;
    #12;
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", a_out_valid); end
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", a_in_ready); end
    total++; if (a_pc !== 64'h0 || a_imm !== 64'h0) begin bad++; $display("FAIL reset_data got pc=%h imm=%h want 0", a_pc, a_imm); end
    total++; if (a_ctl !== '0 || a_ill !== 1'b0 || a_rd !== 5'd0) begin bad++; $display("FAIL reset_ctl got ctl=%h ill=%b rd=%0d want 0", a_ctl, a_ill, a_rd); end
    @(negedge clk);
    resetn = 1'b1;
    step();
  endtask

  task automatic test_addi();
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 64'h100; in_instr = 32'h00500093;
    step();
    in_valid = 1'b0;
    total++; if (a_out_valid !== 1'b1 || a_pc !== 64'h100) begin bad++; $display("FAIL addi_valid got v=%b pc=%h want v=1 pc=100", a_out_valid, a_pc); end
    total++; if (a_rd !== 5'd1 || a_rs1 !== 5'd0) begin bad++; $display("FAIL addi_regs got rd=%0d rs1=%0d want rd=1 rs1=0", a_rd, a_rs1); end
    total++; if (a_imm !== 64'd5) begin bad++; $display("FAIL addi_imm got=%h want=5", a_imm); end
    total++; if (a_ctl.regWrite !== 1'b1 || a_ctl.selectB !== 1'b1 || a_ctl.alufunc !== ALU_ADD || a_ill !== 1'b0)
      begin bad++; $display("FAIL addi_ctl got wr=%b selB=%b alu=%0d ill=%b want 1 1 ADD 0", a_ctl.regWrite, a_ctl.selectB, a_ctl.alufunc, a_ill); end
    step();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL addi_drain got=%b want=0", a_out_valid); end
  endtask

  task automatic test_branch();
    in_valid = 1'b1; in_pc = 64'h180; in_instr = 32'hFE208EE3;
    step();
    in_valid = 1'b0;
    total++; if (a_imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL beq_imm64 got=%h want=fffffffffffffffc", a_imm); end
    total++; if (h_imm !== 32'hFFFF_FFFC) begin bad++; $display("FAIL beq_imm32 got=%h want=fffffffc", h_imm); end
    total++; if (a_ctl.branch !== BRANCH_BEQ || a_ctl.alufunc !== ALU_SUB || a_ctl.regWrite !== 1'b0 || a_ctl.pcSrc !== 1'b1)
      begin bad++; $display("FAIL beq_ctl got br=%0d alu=%0d wr=%b pcsrc=%b want BEQ SUB 0 1", a_ctl.branch, a_ctl.alufunc, a_ctl.regWrite, a_ctl.pcSrc); end
    total++; if (a_rs1 !== 5'd1 || a_rs2 !== 5'd2) begin bad++; $display("FAIL beq_regs got rs1=%0d rs2=%0d want 1 2", a_rs1, a_rs2); end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 64'h200; in_instr = 32'h00500093;
    step();
    in_pc = 64'h204; in_instr = 32'h00700113;
    step();
    in_valid = 1'b0;
    total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_ready got=%b want=0", a_in_ready); end
    total++; if (a_out_valid !== 1'b1 || a_pc !== 64'h200 || a_imm !== 64'd5) begin bad++; $display("FAIL b2b_hold_a got v=%b pc=%h imm=%h want 1 200 5", a_out_valid, a_pc, a_imm); end
    step();
    total++; if (a_pc !== 64'h200 || a_rd !== 5'd1 || a_in_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall got pc=%h rd=%0d rdy=%b want 200 1 0", a_pc, a_rd, a_in_ready); end
    out_ready = 1'b1;
    step();
    total++; if (a_out_valid !== 1'b1 || a_pc !== 64'h204 || a_imm !== 64'd7 || a_rd !== 5'd2)
      begin bad++; $display("FAIL b2b_b got v=%b pc=%h imm=%h rd=%0d want 1 204 7 2", a_out_valid, a_pc, a_imm, a_rd); end
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_back got=%b want=1", a_in_ready); end
    step();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b want=0", a_out_valid); end
  endtask

  task automatic test_flush();
    int seen = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 64'h300; in_instr = 32'h00100093;
    step();
    in_pc = 64'h304;
    step();
    in_pc = 64'h308; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin bad++; $display("FAIL flush_clear got v=%b rdy=%b want 0 1", a_out_valid, a_in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (a_out_valid === 1'b1) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL flush_ghost got=%0d outputs want=0", seen); end
    in_valid = 1'b1; in_pc = 64'h30C;
    step();
    in_valid = 1'b0;
    total++; if (a_out_valid !== 1'b1 || a_pc !== 64'h30C) begin bad++; $display("FAIL flush_resume got v=%b pc=%h want 1 30c", a_out_valid, a_pc); end
    step();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    in_valid = 1'b1; in_pc = 64'h400; in_instr = 32'hFFFFFFFF;
    step();
    in_pc = 64'h404; in_instr = 32'h02208033;
    total++; if (a_out_valid !== 1'b1 || a_ill !== 1'b1 || a_ctl !== '0) begin bad++; $display("FAIL illegal_ones got v=%b ill=%b ctl=%h want 1 1 0", a_out_valid, a_ill, a_ctl); end
    step();
    in_valid = 1'b0;
    total++; if (a_ill !== 1'b1 || a_ctl !== '0) begin bad++; $display("FAIL mul_nom got ill=%b ctl=%h want 1 0", a_ill, a_ctl); end
    total++; if (m_ill !== 1'b0 || m_ctl.alufunc !== ALU_MUL || m_ctl.regWrite !== 1'b1 || m_rs2 !== 5'd2)
      begin bad++; $display("FAIL mul_m got ill=%b alu=%0d wr=%b rs2=%0d want 0 MUL 1 2", m_ill, m_ctl.alufunc, m_ctl.regWrite, m_rs2); end
    step();
  endtask

  task automatic test_xlen32();
    out_ready = 1'b1;
    in_valid = 1'b1; in_pc = 64'h480; in_instr = 32'h02009093;
    step();
    in_instr = 32'h0010809B;
    total++; if (h_ill !== 1'b1) begin bad++; $display("FAIL slli32_rv32 got ill=%b want=1", h_ill); end
    total++; if (a_ill !== 1'b0 || a_ctl.alufunc !== ALU_SLL || a_imm !== 64'd32) begin bad++; $display("FAIL slli32_rv64 got ill=%b alu=%0d imm=%h want 0 SLL 20", a_ill, a_ctl.alufunc, a_imm); end
    step();
    in_instr = 32'h00003083;
    total++; if (h_ill !== 1'b1 || h_ctl !== '0) begin bad++; $display("FAIL addiw_rv32 got ill=%b ctl=%h want 1 0", h_ill, h_ctl); end
    total++; if (a_ill !== 1'b0 || a_ctl.extAluOut !== 1'b1 || a_ctl.alufunc !== ALU_ADDW) begin bad++; $display("FAIL addiw_rv64 got ill=%b ext=%b alu=%0d want 0 1 ADDW", a_ill, a_ctl.extAluOut, a_ctl.alufunc); end
    step();
    in_valid = 1'b0;
    total++; if (h_ill !== 1'b1) begin bad++; $display("FAIL ld_rv32 got ill=%b want=1", h_ill); end
    total++; if (a_ill !== 1'b0 || a_ctl.memRw !== MEM_READ || a_ctl.wbSelect !== WB_MEM) begin bad++; $display("FAIL ld_rv64 got ill=%b mem=%0d wb=%0d want 0 READ MEM", a_ill, a_ctl.memRw, a_ctl.wbSelect); end
    step();
  endtask

  task automatic test_stream();
    logic [31:0] ins [4];
    logic [63:0] exp [4];
    ins[0] = 32'h00100093; exp[0] = 64'h1;
    ins[1] = 32'hFFF00113; exp[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    ins[2] = 32'h800002B7; exp[2] = 64'hFFFF_FFFF_8000_0000;
    ins[3] = 32'h0020A423; exp[3] = 64'h8;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 64'h500 + 64'(4 * i); in_instr = ins[i];
      step();
      total++;
      if (a_out_valid !== 1'b1 || a_pc !== 64'h500 + 64'(4 * i) || a_imm !== exp[i] || a_in_ready !== 1'b1) begin
        bad++; $display("FAIL stream_%0d got v=%b pc=%h imm=%h rdy=%b want 1 %h %h 1", i, a_out_valid, a_pc, a_imm, a_in_ready, 64'h500 + 64'(4 * i), exp[i]);
      end
    end
    in_valid = 1'b0;
    total++; if (a_ctl.memRw !== MEM_WRITE || a_ctl.regWrite !== 1'b0) begin bad++; $display("FAIL stream_sw_ctl got mem=%0d wr=%b want WRITE 0", a_ctl.memRw, a_ctl.regWrite); end
    step();
  endtask

  task automatic test_midreset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 64'h600; in_instr = 32'h00100093;
    step();
    in_pc = 64'h604;
    step();
    in_valid = 1'b0;
    resetn = 1'b0;
    #1;
    total++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_pc !== 64'h0) begin bad++; $display("FAIL midreset got v=%b rdy=%b pc=%h want 0 1 0", a_out_valid, a_in_ready, a_pc); end
    @(negedge clk);
    resetn = 1'b1; out_ready = 1'b1;
    step();
    step();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL midreset_after got v=%b want 0", a_out_valid); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_xlen32();
    test_stream();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
